node_traffic_source: RTL and testbench
======================================

NODE_TRAFFIC_SOURCE -- requirements
Module: node_traffic_source

Interface
REQ-001 SHALL have parameter X_NODES, default 3, mesh columns.
REQ-002 SHALL have parameter Y_NODES, default 3, mesh rows; N = X_NODES*Y_NODES, ADDR_W = $clog2(N).
REQ-003 SHALL have parameter FIFO_WIDTH, default 32, word width; must be at least 2*ADDR_W+8.
REQ-004 SHALL have parameter NODE_ID, default 0, this node's index (0..N-1).
REQ-005 SHALL have parameter MODE, default 1: 0 = fixed destination, 1 = LFSR-random destination.
REQ-006 SHALL have parameter FIXED_DEST, default 8, destination used in MODE 0.
REQ-007 SHALL have parameter RATE, default 256, injection rate in 1/256 words per cycle (1..256).
REQ-008 SHALL have parameter BACKLOG_MAX, default 8, maximum number of generated-but-unsent words.
REQ-009 SHALL have port clk, input, 1 bit, single clock; all state on rising edge.
REQ-010 SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-011 SHALL have port start, input, 1 bit, begin a run (sampled in IDLE only).
REQ-012 SHALL have port packetCount, input, 16 bits, words to generate in the run (0 = none).
REQ-013 SHALL have port holdRequestIn, input, 1 bit, network cannot accept a word this cycle.
REQ-014 SHALL have port dataOut, output, FIFO_WIDTH bits, word to network.
REQ-015 SHALL have port writeRequestOut, output, 1 bit, dataOut valid this cycle.
REQ-016 SHALL have port busy, output, 1 bit, high in RUN or DRAIN.
REQ-017 SHALL have port done, output, 1 bit, one-cycle pulse at end of run.
REQ-018 SHALL have port dropCount, output, 16 bits, words lost to backlog overflow in the current run (saturates at FFFF).

Function
REQ-019 SHALL use word format: [W-1 -: ADDR_W] destination, next ADDR_W bits NODE_ID, low W-2*ADDR_W bits sequence number (wrapping).
REQ-020 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start=1 (clear generated count, sequence, dropCount, backlog); RUN->DRAIN when generated count reaches packetCount; DRAIN->DONE when backlog=0 and no send this edge; DONE->IDLE after one cycle with done=1.
REQ-021 SHALL in IDLE with start=1 and packetCount=0 go directly to DONE.
REQ-022 SHALL in RUN add RATE to a 9-bit accumulator each cycle (acc <= acc[7:0]+RATE), generating one word on carry (acc[8]); RATE=256 generates every RUN cycle.
REQ-023 SHALL on generation with backlog=BACKLOG_MAX discard the word, increment dropCount, and still count it as generated.
REQ-024 SHALL register outputs: on an edge with backlog>0 and holdRequestIn=0, drive writeRequestOut=1 and dataOut=next word for the following cycle, decrement backlog, increment sequence; otherwise writeRequestOut=0 and dataOut holds.
REQ-025 SHALL on simultaneous generation and send leave backlog unchanged.
REQ-026 SHALL in MODE 1 use 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, seed 16'hACE1^NODE_ID, advanced per sent word; dest = lfsr mod N, replaced by (dest+1) mod N if equal to NODE_ID.
REQ-027 SHALL in MODE 0 use FIXED_DEST for every word, including FIXED_DEST=NODE_ID.
REQ-028 SHALL give latency: start sampled at edge k -> first generation at edge k+1 -> writeRequestOut high in the cycle after edge k+2 (RATE=256, no hold).
REQ-029 SHALL ignore start outside IDLE.

Reset
REQ-030 SHALL on reset=0, at any time including mid-run, immediately force IDLE, writeRequestOut=0, dataOut=0, busy=0, done=0, dropCount=0, backlog=0, accumulator=0, sequence=0, LFSR=seed.
REQ-031 SHALL resume only on a new start after reset returns to 1.

Verification
REQ-032 SHALL verify: MODE 0, NODE_ID=8, FIXED_DEST=0, RATE=256, packetCount=3, hold=0 -> writeRequestOut high 3 consecutive cycles from edge k+2, sequence 0,1,2, done pulse once.
REQ-033 SHALL verify: RATE=64, packetCount=4, hold=0 -> one word every 4 cycles, dropCount=0.
REQ-034 SHALL verify: RATE=256, BACKLOG_MAX=8, packetCount=20, hold=1 throughout RUN -> no writes in RUN, dropCount=12, DRAIN sends 8 words after hold release.
REQ-035 SHALL verify: MODE 1, NODE_ID=4, 1000 words -> no destination equals 4, all destinations < N, sequence wraps correctly.
REQ-036 SHALL verify: reset=0 asserted mid-DRAIN -> all outputs zero asynchronously; subsequent start begins with sequence 0 and seeded LFSR.
REQ-037 SHALL verify: start pulsed during RUN and packetCount=0 in IDLE -> former ignored, latter gives done one cycle after start with no writes.

Source files
------------

// File: rtl/node_traffic_source.sv
// node_traffic_source
//   Synthetic traffic generator for one node of an X_NODES x Y_NODES mesh.
//   A run is started with `start` and produces `packetCount` words. Words are
//   generated at RATE/256 words per cycle into a backlog counter and sent to
//   the network whenever the backlog is non-empty and the network is not
//   holding. Word contents (destination, sequence) are formed at send time.
//
// Ports
//   clk             : clock, all state on rising edge
//   reset           : asynchronous active-low reset
//   start           : begin a run (only looked at in IDLE)
//   packetCount     : number of words to generate in the run
//   holdRequestIn   : network cannot take a word this cycle
//   dataOut         : {dest, NODE_ID, sequence} word to network (registered)
//   writeRequestOut : dataOut valid this cycle (registered)
//   busy            : run in progress (RUN or DRAIN)
//   done            : one-cycle pulse at end of run
//   dropCount       : words discarded because the backlog was full (saturating)
module node_traffic_source #(
    parameter int X_NODES     = 3,
    parameter int Y_NODES     = 3,
    parameter int FIFO_WIDTH  = 32,
    parameter int NODE_ID     = 0,
    parameter int MODE        = 1,
    parameter int FIXED_DEST  = 8,
    parameter int RATE        = 256,
    parameter int BACKLOG_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           packetCount,
    input  logic                  holdRequestIn,
    output logic [FIFO_WIDTH-1:0] dataOut,
    output logic                  writeRequestOut,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           dropCount
);
    localparam int N      = X_NODES * Y_NODES;
    localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
    localparam int SEQ_W  = FIFO_WIDTH - 2 * ADDR_W;
    localparam int BL_W   = $clog2(BACKLOG_MAX + 1);
    localparam int ALT_D  = (NODE_ID + 1) % N;
    localparam logic [15:0] SEED = 16'hACE1 ^ 16'(NODE_ID);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [7:0]              r_acc;
    logic [15:0]             r_gen_cnt;
    logic [15:0]             r_target;
    logic [SEQ_W-1:0]        r_seq;
    logic [BL_W-1:0]         r_backlog;
    logic [15:0]             r_drop;
    logic [15:0]             r_lfsr;
    logic [FIFO_WIDTH-1:0]   r_data;
    logic                    r_wr;

    logic [8:0]              w_acc_sum;
    logic                    w_gen;
    logic                    w_full;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_send;
    logic [15:0]             w_gen_next;
    logic [ADDR_W-1:0]       w_rand_raw;
    logic [ADDR_W-1:0]       w_dest;
    logic [FIFO_WIDTH-1:0]   w_word;
    logic [15:0]             w_lfsr_nxt;

    // Rate accumulator: only the low 8 bits are kept; the carry of this
    // cycle's sum is the generate strobe, so RATE=256 generates on every
    // RUN edge starting with the first one after start.
    assign w_acc_sum  = {1'b0, r_acc} + 9'(RATE);
    assign w_gen      = (r_state == S_RUN) && w_acc_sum[8];
    assign w_full     = (r_backlog == BL_W'(BACKLOG_MAX));
    assign w_accept   = w_gen && !w_full;
    assign w_drop     = w_gen && w_full;
    assign w_send     = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                        (r_backlog != '0) && !holdRequestIn;
    assign w_gen_next = r_gen_cnt + 16'd1;

    // Random destination never targets this node: a hit is bumped to the next.
    assign w_rand_raw = ADDR_W'(r_lfsr % 16'(N));
    assign w_dest     = (MODE == 0) ? ADDR_W'(FIXED_DEST) :
                        (w_rand_raw == ADDR_W'(NODE_ID)) ? ADDR_W'(ALT_D) : w_rand_raw;
    assign w_word     = {w_dest, ADDR_W'(NODE_ID), r_seq};

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (right-shifting form)
    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = (packetCount == 16'd0) ? S_DONE : S_RUN;
            S_RUN:   if (w_gen && (w_gen_next == r_target)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_backlog == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_gen_cnt <= '0;
            r_target  <= '0;
            r_seq     <= '0;
            r_backlog <= '0;
            r_drop    <= '0;
            r_lfsr    <= SEED;
            r_data    <= '0;
            r_wr      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_acc     <= '0;
                r_gen_cnt <= '0;
                r_target  <= packetCount;
                r_seq     <= '0;
                r_backlog <= '0;
                r_drop    <= '0;
            end else begin
                if (r_state == S_RUN) begin
                    r_acc <= w_acc_sum[7:0];
                    if (w_gen) r_gen_cnt <= w_gen_next;
                end
                if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
                unique case ({w_accept, w_send})
                    2'b10:   r_backlog <= r_backlog + BL_W'(1);
                    2'b01:   r_backlog <= r_backlog - BL_W'(1);
                    default: r_backlog <= r_backlog;
                endcase
                if (w_send) begin
                    r_seq  <= r_seq + SEQ_W'(1);
                    r_lfsr <= w_lfsr_nxt;
                end
            end
            r_wr <= w_send;
            if (w_send) r_data <= w_word;
        end
    end

    assign dataOut         = r_data;
    assign writeRequestOut = r_wr;
    assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign dropCount       = r_drop;

endmodule

// File: tb/tb_node_traffic_source.sv
module tb_node_traffic_source;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // A: MODE 0, NODE_ID 8, FIXED_DEST 0, RATE 256
    logic        a_start, a_hold, a_wr, a_busy, a_done;
    logic [15:0] a_pc, a_drop;
    logic [31:0] a_data;
    // B: MODE 0, NODE_ID 0, FIXED_DEST 8, RATE 64
    logic        b_start, b_hold, b_wr, b_busy, b_done;
    logic [15:0] b_pc, b_drop;
    logic [31:0] b_data;
    // C: MODE 1, NODE_ID 4, 16-bit words (8-bit sequence)
    logic        c_start, c_hold, c_wr, c_busy, c_done;
    logic [15:0] c_pc, c_drop;
    logic [15:0] c_data;

    int errors = 0;
    int checks = 0;

    node_traffic_source #(.X_NODES(3), .Y_NODES(3), .FIFO_WIDTH(32), .NODE_ID(8), .MODE(0),
        .FIXED_DEST(0), .RATE(256), .BACKLOG_MAX(8)) u_a (
        .clk(clk), .reset(rst_n), .start(a_start), .packetCount(a_pc), .holdRequestIn(a_hold),
        .dataOut(a_data), .writeRequestOut(a_wr), .busy(a_busy), .done(a_done), .dropCount(a_drop));

    node_traffic_source #(.X_NODES(3), .Y_NODES(3), .FIFO_WIDTH(32), .NODE_ID(0), .MODE(0),
        .FIXED_DEST(8), .RATE(64), .BACKLOG_MAX(8)) u_b (
        .clk(clk), .reset(rst_n), .start(b_start), .packetCount(b_pc), .holdRequestIn(b_hold),
        .dataOut(b_data), .writeRequestOut(b_wr), .busy(b_busy), .done(b_done), .dropCount(b_drop));

    node_traffic_source #(.X_NODES(3), .Y_NODES(3), .FIFO_WIDTH(16), .NODE_ID(4), .MODE(1),
        .FIXED_DEST(8), .RATE(256), .BACKLOG_MAX(8)) u_c (
        .clk(clk), .reset(rst_n), .start(c_start), .packetCount(c_pc), .holdRequestIn(c_hold),
        .dataOut(c_data), .writeRequestOut(c_wr), .busy(c_busy), .done(c_done), .dropCount(c_drop));

    // Reference LFSR for random destinations
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [3:0] rand_dest(input logic [15:0] l);
        int d;
        d = int'(l % 16'd9);
        if (d == 4) d = 5;
        return 4'(d);
    endfunction

    // One rising edge, then land on the following falling edge for sampling.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_start = 0; a_hold = 0; a_pc = 0;
        b_start = 0; b_hold = 0; b_pc = 0;
        c_start = 0; c_hold = 0; c_pc = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a_wr, a_busy, a_done, b_wr, b_busy, b_done, c_wr, c_busy, c_done} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0",
                     {a_wr, a_busy, a_done, b_wr, b_busy, b_done, c_wr, c_busy, c_done});
        end
        checks++;
        if ({a_data, b_data, c_data} !== 80'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0", a_data, b_data, c_data);
        end
        checks++;
        if ({a_drop, b_drop, c_drop} !== 48'b0) begin
            errors++;
            $display("FAIL reset_drop: got %h %h %h want 0", a_drop, b_drop, c_drop);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // 3 words back to back from edge k+2, sequence 0,1,2, single done pulse
    task automatic test_fixed_dest;
        int ndone;
        logic exp_wr;
        ndone = 0;
        a_pc = 16'd3; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_wr !== 1'b0) begin
            errors++;
            $display("FAIL fixed_start: busy=%b wr=%b want busy=1 wr=0", a_busy, a_wr);
        end
        for (int j = 1; j <= 6; j++) begin
            tick();
            exp_wr = (j >= 2 && j <= 4);
            checks++;
            if (a_wr !== exp_wr) begin
                errors++;
                $display("FAIL fixed_wr j=%0d: got %b want %b", j, a_wr, exp_wr);
            end
            if (exp_wr) begin
                checks++;
                if (a_data !== {4'd0, 4'd8, 24'(j - 2)}) begin
                    errors++;
                    $display("FAIL fixed_data j=%0d: got %h want %h", j, a_data, {4'd0, 4'd8, 24'(j - 2)});
                end
            end
            if (a_done === 1'b1) ndone++;
            if (j == 5) begin
                checks++;
                if (a_done !== 1'b1 || a_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fixed_done: done=%b busy=%b want 1 0", a_done, a_busy);
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL fixed_done_count: got %0d want 1", ndone);
        end
    endtask

    // RATE 64: one word every 4 cycles, first generated at edge k+4
    task automatic test_rate;
        int n;
        logic exp_wr;
        n = 0;
        b_pc = 16'd4; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int j = 1; j <= 19; j++) begin
            tick();
            exp_wr = (j >= 5 && j <= 17 && ((j - 5) % 4) == 0);
            checks++;
            if (b_wr !== exp_wr) begin
                errors++;
                $display("FAIL rate_wr j=%0d: got %b want %b", j, b_wr, exp_wr);
            end
            if (exp_wr) begin
                checks++;
                if (b_data !== {4'd8, 4'd0, 24'(n)}) begin
                    errors++;
                    $display("FAIL rate_data j=%0d: got %h want %h", j, b_data, {4'd8, 4'd0, 24'(n)});
                end
                n++;
            end
            checks++;
            if (b_done !== (j == 18)) begin
                errors++;
                $display("FAIL rate_done j=%0d: got %b want %b", j, b_done, (j == 18));
            end
        end
        checks++;
        if (b_drop !== 16'd0) begin
            errors++;
            $display("FAIL rate_drop: got %0d want 0", b_drop);
        end
    endtask

    // Hold through RUN: backlog fills to 8, 12 drops, 8 words in DRAIN
    task automatic test_backlog;
        int nwr;
        nwr = 0;
        a_pc = 16'd20; a_hold = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (a_wr !== 1'b0) nwr++;
        end
        checks++;
        if (nwr != 0) begin
            errors++;
            $display("FAIL backlog_run_writes: got %0d want 0", nwr);
        end
        checks++;
        if (a_drop !== 16'd12 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL backlog_drop: drop=%0d busy=%b want 12 1", a_drop, a_busy);
        end
        a_hold = 1'b0;
        for (int j = 21; j <= 29; j++) begin
            tick();
            checks++;
            if (a_wr !== (j <= 28)) begin
                errors++;
                $display("FAIL backlog_wr j=%0d: got %b want %b", j, a_wr, (j <= 28));
            end
            if (j <= 28) begin
                checks++;
                if (a_data !== {4'd0, 4'd8, 24'(j - 21)}) begin
                    errors++;
                    $display("FAIL backlog_data j=%0d: got %h want %h", j, a_data, {4'd0, 4'd8, 24'(j - 21)});
                end
            end
        end
        checks++;
        if (a_done !== 1'b1 || a_drop !== 16'd12) begin
            errors++;
            $display("FAIL backlog_end: done=%b drop=%0d want 1 12", a_done, a_drop);
        end
        tick();
    endtask

    // start pulses during RUN/DRAIN must not disturb the run
    task automatic test_start_ignored;
        logic exp_wr;
        a_pc = 16'd5; a_start = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            a_start = (j == 3 || j == 6);
            tick();
            exp_wr = (j >= 2 && j <= 6);
            checks++;
            if (a_wr !== exp_wr || (exp_wr && a_data !== {4'd0, 4'd8, 24'(j - 2)})) begin
                errors++;
                $display("FAIL ignore_word j=%0d: wr=%b data=%h want wr=%b seq=%0d", j, a_wr, a_data, exp_wr, j - 2);
            end
            checks++;
            if (a_done !== (j == 7)) begin
                errors++;
                $display("FAIL ignore_done j=%0d: got %b want %b", j, a_done, (j == 7));
            end
        end
        a_start = 1'b0;
    endtask

    // packetCount=0: straight to DONE, no writes
    task automatic test_zero_count;
        a_pc = 16'd0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_wr !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b wr=%b want 1 0 0", a_done, a_busy, a_wr);
        end
        tick();
        checks++;
        if (a_done !== 1'b0 || a_wr !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: done=%b wr=%b want 0 0", a_done, a_wr);
        end
    endtask

    // 1000 random-destination words: never self, in range, sequence wraps at 256
    task automatic test_random;
        int n;
        logic seen_done;
        logic [15:0] l;
        logic [3:0] d;
        n = 0; seen_done = 1'b0;
        l = 16'hACE1 ^ 16'd4;
        c_pc = 16'd1000; c_hold = 1'b0; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int cyc = 0; cyc < 1100 && !seen_done; cyc++) begin
            tick();
            if (c_wr === 1'b1) begin
                d = rand_dest(l);
                l = lfsr_step(l);
                if (n == 0) begin
                    checks++;
                    if (c_data[15:12] !== 4'd8) begin
                        errors++;
                        $display("FAIL rand_first_dest: got %0d want 8", c_data[15:12]);
                    end
                end
                checks++;
                if (c_data[15:12] === 4'd4 || c_data[15:12] >= 4'd9) begin
                    errors++;
                    $display("FAIL rand_dest_range n=%0d: got %0d want <9 and !=4", n, c_data[15:12]);
                end
                checks++;
                if (c_data[15:12] !== d) begin
                    errors++;
                    $display("FAIL rand_dest n=%0d: got %0d want %0d", n, c_data[15:12], d);
                end
                checks++;
                if (c_data[11:0] !== {4'd4, 8'(n)}) begin
                    errors++;
                    $display("FAIL rand_src_seq n=%0d: got %h want %h", n, c_data[11:0], {4'd4, 8'(n)});
                end
                n++;
            end
            if (c_done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (n != 1000 || !seen_done) begin
            errors++;
            $display("FAIL rand_total: words=%0d done=%b want 1000 1", n, seen_done);
        end
        tick();
    endtask

    // Asynchronous reset in DRAIN, then a fresh run restarts sequence and LFSR
    task automatic test_reset_mid_drain;
        c_pc = 16'd10; c_hold = 1'b1; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int j = 1; j <= 10; j++) tick();
        c_hold = 1'b0;
        tick();
        tick();
        checks++;
        if (c_wr !== 1'b1 || c_busy !== 1'b1 || c_drop !== 16'd2) begin
            errors++;
            $display("FAIL drain_pre: wr=%b busy=%b drop=%0d want 1 1 2", c_wr, c_busy, c_drop);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (c_wr !== 1'b0 || c_data !== 16'h0 || c_busy !== 1'b0 || c_done !== 1'b0 || c_drop !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: wr=%b data=%h busy=%b done=%b drop=%0d want all 0",
                     c_wr, c_data, c_busy, c_done, c_drop);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (c_busy !== 1'b0 || c_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resume: busy=%b wr=%b want 0 0", c_busy, c_wr);
        end
        c_pc = 16'd2; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        tick();
        tick();
        checks++;
        if (c_wr !== 1'b1 || c_data !== 16'h8400) begin
            errors++;
            $display("FAIL restart_first: wr=%b data=%h want 1 8400", c_wr, c_data);
        end
        for (int j = 0; j < 5; j++) tick();
        checks++;
        if (c_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: busy=%b want 0", c_busy);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_dest();
        test_rate();
        test_backlog();
        test_start_ignored();
        test_zero_count();
        test_random();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
